uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 19 +
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg -- shared definitions for the two-requester UART TX arbiter.
//   state_t          : 2-bit FSM encoding (S_IDLE=0, S_WAIT=1, S_SEND=2, S_FETCH=3)
//   TIMEOUT_CYC_DEF  : default S_WAIT timeout length in cycles
//   TO_W_DEF         : default timeout counter width
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SEND  = 2'd2,
    S_FETCH = 2'd3
  } state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 100000;
  localparam int unsigned TO_W_DEF        = 17;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin pick.
//   valid [1:0] : requesters currently offering a byte
//   rr          : tie-break pointer, 0 favours requester 0, 1 favours requester 1
//   pick  [1:0] : one-hot winner, 2'b00 when nobody is valid
// The pointer only matters on a tie; a lone valid requester always wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] pick
);

  always_comb begin
    pick = valid;
    if (valid == 2'b11) begin
      pick = rr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- shares one UART transmitter between two byte-stream
// requesters. A requester owns the transmitter for a whole message (until a
// byte marked last has been sent); owners alternate round-robin on ties.
//
// Ports
//   clk, reset (async, active low)
//   reqN_valid/reqN_byte/reqN_last : requester N offers a byte (N = 0, 1)
//   reqN_ready                     : byte taken this cycle (combinational)
//   transmit, tx_byte              : start request and byte to the UART
//   is_transmitting                : UART busy flag
//   grant                          : one-hot message owner, 2'b00 when idle
//   busy                           : a message is in progress
//   timeout_err                    : one-cycle pulse when S_WAIT is abandoned
//   dbg_state                      : current FSM state (debug)
//
// Handshake: a byte moves on a rising edge when reqN_valid and reqN_ready are
// both 1 in the preceding cycle; ready never rises without the matching valid
// and is never asserted for both requesters at once.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to abandon a message when the
// UART has not started within TIMEOUT_CYC cycles of S_WAIT. Without it the
// counter does not exist, timeout_err is 0 and S_WAIT waits indefinitely.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned TO_W        = TO_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       transmit,
  output logic [7:0] tx_byte,
  input  logic       is_transmitting,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] dbg_state
);

  // The timeout counter must be able to reach TIMEOUT_CYC-1.
  localparam longint unsigned TO_SPAN = 64'd1 << TO_W;
  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > TO_SPAN) begin : g_cfg_check
    $error("uart_tx_arbiter: TIMEOUT_CYC does not fit in TO_W bits");
  end

  state_t     state_q, state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       last_q, last_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_q, rr_d;
  logic [1:0] pick;
  logic [1:0] take;
  logic       to_hit;
  logic       to_fire;

  rr_arb2 u_rr (
    .valid ({req1_valid, req0_valid}),
    .rr    (rr_q),
    .pick  (pick)
  );

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    last_d    = last_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    take      = 2'b00;
    transmit  = 1'b0;
    to_fire   = 1'b0;

    case (state_q)
      S_IDLE:  take = pick;
      S_WAIT: begin
        transmit = 1'b1;
        if (is_transmitting) begin
          state_d = S_SEND;
        end else if (to_hit) begin
          // Abandon the message exactly like a normal completion.
          to_fire = 1'b1;
          state_d = S_IDLE;
          grant_d = 2'b00;
          rr_d    = grant_q[0];
        end
      end
      S_SEND: begin
        if (!is_transmitting) begin
          if (last_q) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
            // Owner 0 just finished -> favour requester 1 next, and vice versa.
            rr_d    = grant_q[0];
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: take = grant_q & {req1_valid, req0_valid};
      default: state_d = S_IDLE;
    endcase

    if (take != 2'b00) begin
      tx_byte_d = take[1] ? req1_byte : req0_byte;
      last_d    = take[1] ? req1_last : req0_last;
      grant_d   = take;
      state_d   = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tx_byte_q <= 8'h00;
      last_q    <= 1'b0;
      grant_q   <= 2'b00;
      rr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts completed cycles of the current S_WAIT visit; zero on entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Readies are combinational from the idle state, so they are gated with the
  // reset input to stay low while reset is held even if a requester is valid.
  assign req0_ready  = take[0] & reset;
  assign req1_ready  = take[1] & reset;
  assign tx_byte     = tx_byte_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = to_fire;
  assign dbg_state   = state_q;

endmodule
